// File: rtl/pipe_rf_pkg.sv
// Shared types and defaults for the pipelined register file with busy scoreboard.
package pipe_rf_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 4;

    // Register index at the default address width.
    typedef logic [DefAddrW-1:0] reg_idx_t;

    // Where the effective (write-first) value of a register comes from this cycle.
    typedef enum logic [1:0] {
        SrcStore,
        SrcPortA,
        SrcPortB
    } wr_src_e;

    // Port B is the younger writer when both ports hit the same register.
    localparam bit PrioPortB = 1'b1;

    // Resolve the source of a register's effective value from the two write hits.
    function automatic wr_src_e eff_read(input logic hit_a, input logic hit_b);
        if (hit_a && hit_b) begin
            return PrioPortB ? SrcPortB : SrcPortA;
        end
        if (hit_b) begin
            return SrcPortB;
        end
        if (hit_a) begin
            return SrcPortA;
        end
        return SrcStore;
    endfunction

endpackage

// File: rtl/pipe_regfile_sb_if.sv
// Bus bundle for the register file: read, write, issue and debug signals.
interface pipe_regfile_sb_if
    import pipe_rf_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic              we_a;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              we_b;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy1;
    logic              busy2;
    logic [Depth-1:0]  busy_vec;

    logic              dbg_sel_en;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    // Pipeline side: drives requests, observes data and hazards.
    modport master (
        output rd_en, rd_addr1, rd_addr2,
        output we_a, wa_addr, wa_data, we_b, wb_addr, wb_data,
        output iss_valid, iss_addr, dbg_sel_en, dbg_addr,
        input  rd_data1, rd_data2, busy1, busy2, busy_vec, dbg_data
    );

    // Register file side.
    modport slave (
        input  rd_en, rd_addr1, rd_addr2,
        input  we_a, wa_addr, wa_data, we_b, wb_addr, wb_data,
        input  iss_valid, iss_addr, dbg_sel_en, dbg_addr,
        output rd_data1, rd_data2, busy1, busy2, busy_vec, dbg_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for decode hazard detection, plus read-port hazard lookup.
module rf_scoreboard
    import pipe_rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned Depth   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] wa_addr_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [Depth-1:0]  busy_vec_o,
    output logic              busy1_o,
    output logic              busy2_o
);

    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;
    logic [Depth-1:0] set_vec;
    logic [Depth-1:0] clr_vec;

    // Decode issue (set) and writeback (clear) per register; set wins as the newer producer.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        busy_d  = busy_q;
        for (int i = 0; i < Depth; i++) begin
            set_vec[i] = iss_valid_i && (iss_addr_i == ADDR_W'(i));
            clr_vec[i] = (we_a_i && (wa_addr_i == ADDR_W'(i))) ||
                         (we_b_i && (wb_addr_i == ADDR_W'(i)));
            if (set_vec[i]) begin
                busy_d[i] = 1'b1;
            end else if (clr_vec[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A write landing this cycle resolves the hazard, matching the read bypass,
    // unless a new producer is issued to the same register in the same cycle.
    always_comb begin
        busy1_o = busy_q[rd_addr1_i] & ~(clr_vec[rd_addr1_i] & ~set_vec[rd_addr1_i]);
        busy2_o = busy_q[rd_addr2_i] & ~(clr_vec[rd_addr2_i] & ~set_vec[rd_addr2_i]);
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/pipe_regfile_sb.sv
// Parametrised register file: two write-first read ports, two write ports (B wins),
// optional hardwired zero register, registered debug tap and busy scoreboard.
module pipe_regfile_sb
    import pipe_rf_pkg::*;
#(
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter bit          ZERO_REG       = 1'b0,
    parameter int unsigned DBG_RESET_ADDR = 15
) (
    input logic              clk,
    input logic              rst,
    pipe_regfile_sb_if.slave bus
);

    localparam int unsigned       Depth      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DbgRstAddr = ADDR_W'(DBG_RESET_ADDR);

    logic [DATA_W-1:0] mem_q [Depth];
    // Next stored value, which is also the write-first view seen by every read port.
    logic [DATA_W-1:0] mem_d [Depth];

    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic [ADDR_W-1:0] dbg_sel_addr;

    // Merge this cycle's writes into the stored values with port B priority.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            case (eff_read(bus.we_a && (bus.wa_addr == ADDR_W'(i)),
                           bus.we_b && (bus.wb_addr == ADDR_W'(i))))
                SrcPortB: mem_d[i] = bus.wb_data;
                SrcPortA: mem_d[i] = bus.wa_data;
                default:  mem_d[i] = mem_q[i];
            endcase
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    // Read and debug port next-state from the write-first view.
    always_comb begin
        rd_data1_d   = rd_data1_q;
        rd_data2_d   = rd_data2_q;
        dbg_sel_addr = bus.dbg_sel_en ? bus.dbg_addr : DbgRstAddr;
        if (bus.rd_en) begin
            rd_data1_d = mem_d[bus.rd_addr1];
            rd_data2_d = mem_d[bus.rd_addr2];
        end
        dbg_data_d = mem_d[dbg_sel_addr];
    end

    // Storage and output registers; reset discards any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            dbg_data_q <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign bus.rd_data1 = rd_data1_q;
    assign bus.rd_data2 = rd_data2_q;
    assign bus.dbg_data = dbg_data_q;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (bus.iss_valid),
        .iss_addr_i  (bus.iss_addr),
        .we_a_i      (bus.we_a),
        .wa_addr_i   (bus.wa_addr),
        .we_b_i      (bus.we_b),
        .wb_addr_i   (bus.wb_addr),
        .rd_addr1_i  (bus.rd_addr1),
        .rd_addr2_i  (bus.rd_addr2),
        .busy_vec_o  (bus.busy_vec),
        .busy1_o     (bus.busy1),
        .busy2_o     (bus.busy2)
    );

endmodule
